queue_drain: RTL

QUEUE_DRAIN -- requirements
Module: queue_drain

---
 rtl/queue_drain_if.sv | 30 +++
 rtl/queue_drain.sv | 107 ++++++++++
 2 files changed

// File: rtl/queue_drain_if.sv
// Signal bundle between queue_drain and its environment: control, queue side and output stream.
// The environment holds the master view and the drain engine holds the slave view.
interface queue_drain_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              abort;
  logic              q_is_empty;
  logic [DATA_W-1:0] q_data;
  logic              q_dequeue;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [LEN_W-1:0]  count;

  modport master (
    output start, burst_len, abort, q_is_empty, q_data, out_ready,
    input  q_dequeue, out_data, out_valid, busy, done, underrun, count
  );

  modport slave (
    input  start, burst_len, abort, q_is_empty, q_data, out_ready,
    output q_dequeue, out_data, out_valid, busy, done, underrun, count
  );
endinterface

// File: rtl/queue_drain.sv
// Drains bytes from an attached queue onto a valid/ready stream, one dequeue at a time,
// for a fixed burst length or until the queue runs empty.
module queue_drain #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  queue_drain_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    CAPT,
    SEND,
    SETTLE,
    FIN
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             abort_q;
  logic             abort_seen;

  // A short abort pulse during CAPT/SEND must still end the drain at the following CHECK.
  assign abort_seen = bus.abort | abort_q;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      abort_q       <= 1'b0;
      bus.q_dequeue <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.count     <= '0;
    end else begin
      bus.q_dequeue <= 1'b0;
      bus.done      <= 1'b0;
      if (bus.abort && state != IDLE) abort_q <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            len_q        <= bus.burst_len;
            bus.count    <= '0;
            bus.underrun <= 1'b0;
            abort_q      <= bus.abort;
            bus.busy     <= 1'b1;
            state        <= CHECK;
          end
        end

        CHECK: begin
          if (abort_seen) begin
            bus.done <= 1'b1;
            state    <= FIN;
          end else if (bus.q_is_empty) begin
            // Only a nonzero burst that is still short of its length counts as an underrun.
            bus.underrun <= (len_q != '0) && (bus.count != len_q);
            bus.done     <= 1'b1;
            state        <= FIN;
          end else if (len_q != '0 && bus.count == len_q) begin
            bus.done <= 1'b1;
            state    <= FIN;
          end else begin
            bus.q_dequeue <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: state <= CAPT;

        CAPT: begin
          bus.out_data  <= bus.q_data;
          bus.out_valid <= 1'b1;
          state         <= SEND;
        end

        SEND: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.count     <= bus.count + 1'b1;
            state         <= SETTLE;
          end
        end

        SETTLE: state <= CHECK;

        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
